// File: rtl/mips32_reg_dump.sv
// mips32_reg_dump: on a rising halted, streams every GPR out as {idx, data} beats.
// Define REG_DUMP_CHECKSUM_EN to add dump_sum, a running sum of accepted beats.
module mips32_reg_dump #(
   parameter int NUM_REGS = 32,
   parameter int DATA_W   = 32,
   parameter int IDX_W    = 5
) (
   input  logic              clk1,
   input  logic              rst_n,
   input  logic              halted,
   output logic [IDX_W-1:0]  rf_rd_addr,
   input  logic [DATA_W-1:0] rf_rd_data,
   output logic              dump_valid,
   input  logic              dump_ready,
   output logic [IDX_W-1:0]  dump_idx,
   output logic [DATA_W-1:0] dump_data,
   output logic              dump_last,
   output logic              busy,
`ifdef REG_DUMP_CHECKSUM_EN
   output logic              done,
   output logic [DATA_W-1:0] dump_sum
`else
   output logic              done
`endif
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_ADDR = 3'd1;
   localparam logic [2:0] S_CAP  = 3'd2;
   localparam logic [2:0] S_SEND = 3'd3;
   localparam logic [2:0] S_DONE = 3'd4;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);

   logic [2:0]        state_q, state_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic              halted_q;
   logic              armed_q, armed_d;
   logic              valid_q, valid_d;
   logic [IDX_W-1:0]  didx_q, didx_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              last_q, last_d;
   logic              start;
   logic              hs;
`ifdef REG_DUMP_CHECKSUM_EN
   logic [DATA_W-1:0] sum_q, sum_d;
`endif

   // halted_q clears on reset, so a halted still high out of reset
   // must be seen low once (armed_q) before it can trigger a dump.
   assign start   = halted & ~halted_q & armed_q;
   assign hs      = valid_q & dump_ready;
   assign armed_d = armed_q | ~halted;

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      valid_d = valid_q;
      didx_d  = didx_q;
      data_d  = data_q;
      last_d  = last_q;
`ifdef REG_DUMP_CHECKSUM_EN
      sum_d   = sum_q;
`endif
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               idx_d   = '0;
               state_d = S_ADDR;
`ifdef REG_DUMP_CHECKSUM_EN
               sum_d   = '0;
`endif
            end
         end
         S_ADDR: state_d = S_CAP;
         S_CAP: begin
            data_d  = rf_rd_data;
            didx_d  = idx_q;
            last_d  = (idx_q == LAST_IDX);
            valid_d = 1'b1;
            state_d = S_SEND;
         end
         S_SEND: begin
            if (hs) begin
               valid_d = 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
               sum_d   = sum_q + data_q;
`endif
               if (last_q) begin
                  state_d = S_DONE;
               end else if (!halted) begin
                  state_d = S_IDLE;
               end else begin
                  idx_d   = idx_q + 1'b1;
                  state_d = S_ADDR;
               end
            end
         end
         S_DONE: begin
            if (!halted) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk1) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         idx_q    <= '0;
         halted_q <= 1'b0;
         armed_q  <= 1'b0;
         valid_q  <= 1'b0;
         didx_q   <= '0;
         data_q   <= '0;
         last_q   <= 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
         sum_q    <= '0;
`endif
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         halted_q <= halted;
         armed_q  <= armed_d;
         valid_q  <= valid_d;
         didx_q   <= didx_d;
         data_q   <= data_d;
         last_q   <= last_d;
`ifdef REG_DUMP_CHECKSUM_EN
         sum_q    <= sum_d;
`endif
      end
   end

   assign rf_rd_addr = idx_q;
   assign dump_valid = valid_q;
   assign dump_idx   = didx_q;
   assign dump_data  = data_q;
   assign dump_last  = last_q;
   assign busy       = (state_q != S_IDLE) && (state_q != S_DONE);
   assign done       = (state_q == S_DONE);
`ifdef REG_DUMP_CHECKSUM_EN
   assign dump_sum   = sum_q;
`endif

endmodule

// File: tb/tb_mips32_reg_dump.sv
// tb_mips32_reg_dump: register-file dump bench with array model and beat scoreboard.
// Build with REG_DUMP_CHECKSUM_EN defined to also cover dump_sum.
module tb_mips32_reg_dump;

   localparam int N = 32;

   localparam int OP_ADD  = 0;
   localparam int OP_ADDI = 1;
   localparam int OP_OR   = 2;
   localparam int OP_HLT  = 3;

   logic        clk1 = 1'b0;
   logic        rst_n = 1'b0;
   logic        halted = 1'b0;
   logic [4:0]  rf_rd_addr;
   logic [31:0] rf_rd_data;
   logic        dump_valid;
   logic        dump_ready = 1'b1;
   logic [4:0]  dump_idx;
   logic [31:0] dump_data;
   logic        dump_last;
   logic        busy;
   logic        done;
`ifdef REG_DUMP_CHECKSUM_EN
   logic [31:0] dump_sum;
`endif

   logic [31:0] rf [N];

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int hs_cyc = 0;
   bit rdy_rand = 1'b0;

   logic [4:0]  q_idx[$];
   logic [31:0] q_data[$];
   logic        q_last[$];

   assign rf_rd_data = rf[rf_rd_addr];

   mips32_reg_dump #(.NUM_REGS(N), .DATA_W(32), .IDX_W(5)) dut (
      .clk1       (clk1),
      .rst_n      (rst_n),
      .halted     (halted),
      .rf_rd_addr (rf_rd_addr),
      .rf_rd_data (rf_rd_data),
      .dump_valid (dump_valid),
      .dump_ready (dump_ready),
      .dump_idx   (dump_idx),
      .dump_data  (dump_data),
      .dump_last  (dump_last),
      .busy       (busy),
`ifdef REG_DUMP_CHECKSUM_EN
      .done       (done),
      .dump_sum   (dump_sum)
`else
      .done       (done)
`endif
   );

   always #5 clk1 = ~clk1;

   always @(posedge clk1) begin
      if (rst_n && dump_valid && dump_ready) begin
         q_idx.push_back(dump_idx);
         q_data.push_back(dump_data);
         q_last.push_back(dump_last);
         hs_cyc = cyc;
      end
   end

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // One clock; a beat stalled before the edge must be unchanged after it.
   task automatic tick();
      logic        st;
      logic [4:0]  si;
      logic [31:0] sd;
      logic        sl;
      if (rdy_rand) dump_ready = ($urandom_range(0, 3) != 0);
      st = rst_n & dump_valid & ~dump_ready;
      si = dump_idx;
      sd = dump_data;
      sl = dump_last;
      @(posedge clk1);
      #1;
      cyc++;
      if (st) begin
         chk("hold_v", dump_valid, 1);
         chk("hold_idx", dump_idx, si);
         chk("hold_dat", dump_data, sd);
         chk("hold_last", dump_last, sl);
      end
   endtask

   task automatic clear_q();
      q_idx.delete();
      q_data.delete();
      q_last.delete();
   endtask

   task automatic run_until(input bit want_done, input int budget,
                            input string tag);
      bit ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         tick();
         if (want_done ? done : !busy) begin
            ok = 1'b1;
            break;
         end
      end
      chk(tag, ok, 1);
   endtask

   task automatic wait_beat(input int k, input int budget, input string tag);
      bit ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         tick();
         if (dump_valid && dump_idx == 5'(k)) begin
            ok = 1'b1;
            break;
         end
      end
      chk(tag, ok, 1);
   endtask

   task automatic cmp_dump(input int n, input string tag);
      chk({tag, "_n"}, q_idx.size(), n);
      for (int i = 0; i < n && i < q_idx.size(); i++) begin
         chk({tag, "_idx"}, q_idx[i], i);
         chk({tag, "_dat"}, q_data[i], rf[i]);
         chk({tag, "_last"}, q_last[i], (i == N - 1));
      end
   endtask

   function automatic logic [31:0] sum_to(input int n);
      logic [31:0] s = '0;
      for (int i = 0; i < n; i++) s += rf[i];
      return s;
   endfunction

   task automatic run_program();
      int p_op[9] = '{OP_ADDI, OP_ADDI, OP_ADDI, OP_OR, OP_OR,
                      OP_ADD, OP_OR, OP_ADD, OP_HLT};
      int p_rd[9] = '{1, 2, 3, 7, 7, 4, 7, 5, 0};
      int p_rs[9] = '{0, 0, 0, 7, 7, 1, 7, 4, 0};
      int p_rt[9] = '{0, 0, 0, 7, 7, 2, 7, 3, 0};
      int p_im[9] = '{10, 20, 25, 0, 0, 0, 0, 0, 0};
      for (int pc = 0; pc < 9; pc++) begin
         if (p_op[pc] == OP_HLT) break;
         case (p_op[pc])
            OP_ADDI: rf[p_rd[pc]] = rf[p_rs[pc]] + 32'(p_im[pc]);
            OP_ADD:  rf[p_rd[pc]] = rf[p_rs[pc]] + rf[p_rt[pc]];
            default: rf[p_rd[pc]] = rf[p_rs[pc]] | rf[p_rt[pc]];
         endcase
      end
   endtask

   initial begin
      int c0;
      int n7;
      logic [31:0] exp_prog [6];
      exp_prog = '{32'd0, 32'd10, 32'd20, 32'd25, 32'd30, 32'd55};
      for (int k = 0; k < N; k++) rf[k] = 32'(k);

      repeat (3) tick();
      chk("rst_addr", rf_rd_addr, 0);
      chk("rst_v", dump_valid, 0);
      chk("rst_idx", dump_idx, 0);
      chk("rst_dat", dump_data, 0);
      chk("rst_last", dump_last, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      rst_n = 1'b1;
      repeat (2) tick();

      // Full dump, ready tied high: latency and cadence.
      clear_q();
      c0 = cyc;
      halted = 1'b1;
      tick();
      chk("lat0_v", dump_valid, 0);
      chk("lat0_busy", busy, 1);
      tick();
      chk("lat1_v", dump_valid, 0);
      tick();
      chk("lat2_v", dump_valid, 1);
      chk("lat2_idx", dump_idx, 0);
      run_until(1'b1, 200, "t1_done");
      chk("t1_busy", busy, 0);
      chk("t1_hs_cyc", hs_cyc, c0 + 96);
      cmp_dump(N, "t1");
`ifdef REG_DUMP_CHECKSUM_EN
      chk("t1_sum", dump_sum, 496);
`endif

      // Program results, random backpressure.
      halted = 1'b0;
      tick();
      chk("t2_done_clr", done, 0);
      run_program();
      clear_q();
      rdy_rand = 1'b1;
      halted = 1'b1;
      run_until(1'b1, 2000, "t2_done");
      rdy_rand = 1'b0;
      dump_ready = 1'b1;
      cmp_dump(N, "t2");
      for (int i = 0; i < 6 && i < q_data.size(); i++)
         chk("t2_prog", q_data[i], exp_prog[i]);
`ifdef REG_DUMP_CHECKSUM_EN
      chk("t2_sum", dump_sum, sum_to(N));
`endif

      // Five-cycle stall on beat 7.
      halted = 1'b0;
      tick();
      clear_q();
      halted = 1'b1;
      wait_beat(7, 100, "t3_reach");
      dump_ready = 1'b0;
      repeat (5) begin
         tick();
         chk("t3_v", dump_valid, 1);
         chk("t3_idx", dump_idx, 7);
         chk("t3_dat", dump_data, rf[7]);
      end
      dump_ready = 1'b1;
      run_until(1'b1, 200, "t3_done");
      cmp_dump(N, "t3");
      n7 = 0;
      foreach (q_idx[i]) if (q_idx[i] == 5'd7) n7++;
      chk("t3_one7", n7, 1);

      // halted falls with beat 12 pending.
      halted = 1'b0;
      tick();
      clear_q();
      halted = 1'b1;
      wait_beat(12, 100, "t4_reach");
      dump_ready = 1'b0;
      halted = 1'b0;
      repeat (2) tick();
      dump_ready = 1'b1;
      run_until(1'b0, 20, "t4_idle");
      chk("t4_busy", busy, 0);
      chk("t4_done", done, 0);
      repeat (10) tick();
      cmp_dump(13, "t4");
`ifdef REG_DUMP_CHECKSUM_EN
      chk("t4_sum", dump_sum, sum_to(13));
`endif
      clear_q();
      halted = 1'b1;
      run_until(1'b1, 200, "t4_re_done");
      cmp_dump(N, "t4_re");

      // Reset during SEND at beat 20.
      halted = 1'b0;
      tick();
      clear_q();
      halted = 1'b1;
      wait_beat(20, 100, "t5_reach");
      dump_ready = 1'b0;
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      dump_ready = 1'b1;
      chk("t5_addr", rf_rd_addr, 0);
      chk("t5_v", dump_valid, 0);
      chk("t5_idx", dump_idx, 0);
      chk("t5_dat", dump_data, 0);
      chk("t5_last", dump_last, 0);
      chk("t5_busy", busy, 0);
      chk("t5_done", done, 0);
      repeat (10) tick();
      chk("t5_nobusy", busy, 0);
      chk("t5_nov", dump_valid, 0);
      chk("t5_n", q_idx.size(), 20);
      halted = 1'b0;
      tick();
      clear_q();
      halted = 1'b1;
      run_until(1'b1, 200, "t5_re_done");
      cmp_dump(N, "t5_re");

      // halted held in DONE, then a second dump.
      repeat (50) tick();
      chk("t6_n", q_idx.size(), N);
      chk("t6_done", done, 1);
      chk("t6_busy", busy, 0);
`ifdef REG_DUMP_CHECKSUM_EN
      chk("t6_sum", dump_sum, sum_to(N));
`endif
      halted = 1'b0;
      tick();
      chk("t6_done_clr", done, 0);
      clear_q();
      rdy_rand = 1'b1;
      halted = 1'b1;
      run_until(1'b1, 2000, "t6_re_done");
      rdy_rand = 1'b0;
      dump_ready = 1'b1;
      cmp_dump(N, "t6_re");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
